// File: rtl/obstacle_collision_ctl.sv
// obstacle_collision_ctl
// Samples the obstacle and player positions once per frame, then tests the
// two bounding boxes for overlap one cycle later. A hit needs HIT_FRAMES
// consecutive overlapping frames. After that, game_over latches until restart.
// Obstacles that the player has fully passed are counted in a saturating score.

module obstacle_collision_ctl #(
  parameter int unsigned OBST_W     = 40,
  parameter int unsigned OBST_H     = 60,
  parameter int unsigned OBST_Y     = 500,
  parameter int unsigned PLAYER_W   = 32,
  parameter int unsigned PLAYER_H   = 48,
  parameter int unsigned HIT_FRAMES = 2,
  parameter int unsigned SCORE_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               restart,
  input  logic [11:0]        obstacle_xpos,
  input  logic [11:0]        player_xpos,
  input  logic [11:0]        player_ypos,
  output logic               game_over,
  output logic               hit_pulse,
  output logic [SCORE_W-1:0] score
);

  // The hit counter only has to reach HIT_FRAMES. When it gets there the FSM
  // leaves RUN, so the counter never wraps.
  localparam int CNT_W = $clog2(HIT_FRAMES + 1);

  localparam logic [12:0] OBST_W13   = 13'(OBST_W);
  localparam logic [12:0] PLAYER_W13 = 13'(PLAYER_W);
  localparam logic [12:0] PLAYER_H13 = 13'(PLAYER_H);
  localparam logic [12:0] OBST_TOP13 = 13'(OBST_Y);
  localparam logic [12:0] OBST_BOT13 = 13'(OBST_Y + OBST_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [11:0]        ox_q, ox_d;
  logic [11:0]        px_q, px_d;
  logic [11:0]        py_q, py_d;
  logic               eval_q, eval_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic               armed_q, armed_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               hit_pulse_q, hit_pulse_d;

  logic [12:0] ox13, px13, py13;
  logic        ox_active;
  logic        overlap;
  logic        ahead;

  // The box test works on 13-bit copies of the sampled positions. This way,
  // adding a width or height to a 12-bit coordinate cannot wrap around.
  always_comb begin
    ox13      = {1'b0, ox_q};
    px13      = {1'b0, px_q};
    py13      = {1'b0, py_q};
    ox_active = (ox_q != 12'd0);
    ahead     = (ox13 + OBST_W13) > px13;
    overlap   = ox_active &&
                (ox13 < (px13 + PLAYER_W13)) &&
                (px13 < (ox13 + OBST_W13)) &&
                (OBST_TOP13 < (py13 + PLAYER_H13)) &&
                (py13 < OBST_BOT13);
  end

  // Latch the positions on frame_start and schedule one evaluation for the
  // following cycle. Restart drops the frame. OVER ignores frames.
  always_comb begin
    ox_d   = ox_q;
    px_d   = px_q;
    py_d   = py_q;
    eval_d = 1'b0;
    if (frame_start && !restart && (state_q != OVER)) begin
      ox_d   = obstacle_xpos;
      px_d   = player_xpos;
      py_d   = player_ypos;
      eval_d = 1'b1;
    end
  end

  // State and datapath registers, with synchronous reset to the idle state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ox_q        <= '0;
      px_q        <= '0;
      py_q        <= '0;
      eval_q      <= 1'b0;
      hit_cnt_q   <= '0;
      armed_q     <= 1'b0;
      score_q     <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ox_q        <= ox_d;
      px_q        <= px_d;
      py_q        <= py_d;
      eval_q      <= eval_d;
      hit_cnt_q   <= hit_cnt_d;
      armed_q     <= armed_d;
      score_q     <= score_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  // Next-state logic. Overlap debouncing and scoring both happen in the
  // evaluation cycle. Overlapping implies the obstacle is still ahead of the
  // player, so an overlapping frame only re-arms and never scores.
  always_comb begin
    state_d     = state_q;
    hit_cnt_d   = hit_cnt_q;
    armed_d     = armed_q;
    score_d     = score_q;
    hit_pulse_d = 1'b0;
    if (restart) begin
      state_d   = IDLE;
      hit_cnt_d = '0;
      armed_d   = 1'b0;
      score_d   = '0;
    end else if (eval_q) begin
      unique case (state_q)
        IDLE: begin
          if (ox_active) begin
            state_d   = RUN;
            hit_cnt_d = '0;
            armed_d   = ahead;
          end
        end
        RUN: begin
          if (overlap) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
            armed_d   = 1'b1;
            if (hit_cnt_d == CNT_W'(HIT_FRAMES)) begin
              state_d     = OVER;
              hit_pulse_d = 1'b1;
            end
          end else begin
            hit_cnt_d = '0;
            if (!ox_active) begin
              armed_d = 1'b0;
            end else if (ahead) begin
              armed_d = 1'b1;
            end else if (armed_q) begin
              armed_d = 1'b0;
              if (score_q != {SCORE_W{1'b1}}) begin
                score_d = score_q + SCORE_W'(1);
              end
            end
          end
        end
        OVER: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Drive the outputs. All three come straight from registered state.
  always_comb begin
    game_over = (state_q == OVER);
    hit_pulse = hit_pulse_q;
    score     = score_q;
  end

endmodule

// File: tb/tb_obstacle_collision_ctl.sv
// tb_obstacle_collision_ctl
// Directed test of obstacle_collision_ctl, with hand-computed expectations.
// A second instance, built with a 2-bit score, exercises score saturation.

module tb_obstacle_collision_ctl;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        restart;
  logic [11:0] obstacle_xpos;
  logic [11:0] player_xpos;
  logic [11:0] player_ypos;

  logic        game_over;
  logic        hit_pulse;
  logic [15:0] score;
  logic        game_over_s;
  logic        hit_pulse_s;
  logic [1:0]  score_s;

  int check_count = 0;
  int error_count = 0;

  obstacle_collision_ctl dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .restart       (restart),
    .obstacle_xpos (obstacle_xpos),
    .player_xpos   (player_xpos),
    .player_ypos   (player_ypos),
    .game_over     (game_over),
    .hit_pulse     (hit_pulse),
    .score         (score)
  );

  obstacle_collision_ctl #(.SCORE_W(2)) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .restart       (restart),
    .obstacle_xpos (obstacle_xpos),
    .player_xpos   (player_xpos),
    .player_ypos   (player_ypos),
    .game_over     (game_over_s),
    .hit_pulse     (hit_pulse_s),
    .score         (score_s)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count the comparison, and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Present one frame. The task returns in the middle of cycle F+2, where the
  // result of the evaluation is visible.
  task automatic applyStimulus(input int ox, input int px, input int py);
    @(negedge clk);
    obstacle_xpos = 12'(ox);
    player_xpos   = 12'(px);
    player_ypos   = 12'(py);
    frame_start   = 1'b1;
    @(negedge clk);
    frame_start   = 1'b0;
    @(negedge clk);
  endtask

  // Sweep one obstacle from the right edge down to x=10, then let it respawn.
  task automatic sweepObstacle();
    for (int x = 750; x >= 10; x -= 20) applyStimulus(x, 100, 300);
    applyStimulus(0, 100, 300);
  endtask

  task automatic pulseRestart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    frame_start   = 1'b0;
    restart       = 1'b0;
    obstacle_xpos = '0;
    player_xpos   = '0;
    player_ypos   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_game_over", 32'(game_over), 0);
    checkOutput("reset_hit_pulse", 32'(hit_pulse), 0);
    checkOutput("reset_score", 32'(score), 0);

    // Obstacle appears far to the right. The FSM enters RUN and arms scoring.
    applyStimulus(750, 100, 300);
    checkOutput("start_game_over", 32'(game_over), 0);
    checkOutput("start_score", 32'(score), 0);

    // Each sweep passes the player once, when x first drops to 60 or below.
    sweepObstacle();
    checkOutput("sweep1_score", 32'(score), 1);
    sweepObstacle();
    sweepObstacle();
    checkOutput("sweep3_score", 32'(score), 3);
    checkOutput("sweep3_score_sat", 32'(score_s), 3);
    sweepObstacle();
    sweepObstacle();
    checkOutput("sweep5_score", 32'(score), 5);
    checkOutput("sweep5_score_sat", 32'(score_s), 3);
    checkOutput("sweep5_game_over", 32'(game_over), 0);

    // Overlapping inputs that arrive without frame_start are never sampled.
    applyStimulus(750, 100, 300);
    @(negedge clk);
    obstacle_xpos = 12'd120;
    player_ypos   = 12'd480;
    repeat (6) @(negedge clk);
    checkOutput("midframe_ignored", 32'(game_over), 0);

    // An overlapping frame, then a clear frame, then another overlap. The
    // clear frame resets the debounce count, so no hit is declared.
    applyStimulus(120, 100, 480);
    applyStimulus(120, 100, 300);
    applyStimulus(120, 100, 480);
    checkOutput("debounce_reset_game_over", 32'(game_over), 0);
    checkOutput("debounce_reset_hit_pulse", 32'(hit_pulse), 0);

    // Two consecutive overlapping frames trigger the hit.
    applyStimulus(120, 100, 300);
    applyStimulus(120, 100, 480);
    checkOutput("hit_frame1_game_over", 32'(game_over), 0);
    applyStimulus(120, 100, 480);
    checkOutput("hit_game_over", 32'(game_over), 1);
    checkOutput("hit_pulse_high", 32'(hit_pulse), 1);
    checkOutput("hit_score_frozen", 32'(score), 5);
    @(negedge clk);
    checkOutput("hit_pulse_one_cycle", 32'(hit_pulse), 0);
    checkOutput("hit_game_over_held", 32'(game_over), 1);

    // OVER ignores frames, including one that would otherwise score.
    applyStimulus(10, 100, 300);
    checkOutput("over_game_over_held", 32'(game_over), 1);
    checkOutput("over_score_held", 32'(score), 5);
    checkOutput("over_no_pulse", 32'(hit_pulse), 0);

    // Restart and frame_start arrive together. The frame must be dropped.
    @(negedge clk);
    obstacle_xpos = 12'd120;
    player_xpos   = 12'd100;
    player_ypos   = 12'd480;
    restart       = 1'b1;
    frame_start   = 1'b1;
    @(negedge clk);
    restart       = 1'b0;
    frame_start   = 1'b0;
    checkOutput("restart_game_over", 32'(game_over), 0);
    checkOutput("restart_score", 32'(score), 0);
    checkOutput("restart_score_sat", 32'(score_s), 0);
    // The first overlap only moves IDLE to RUN. If the dropped frame had been
    // evaluated, the second overlap here would already end the game.
    applyStimulus(120, 100, 480);
    applyStimulus(120, 100, 480);
    checkOutput("dropped_frame_game_over", 32'(game_over), 0);
    applyStimulus(120, 100, 480);
    checkOutput("after_restart_hit", 32'(game_over), 1);

    // A synchronous reset, while a hit-completing frame is pending, discards
    // that evaluation.
    pulseRestart();
    checkOutput("restart2_game_over", 32'(game_over), 0);
    applyStimulus(750, 100, 300);
    applyStimulus(10, 100, 300);
    checkOutput("restart2_score", 32'(score), 1);
    applyStimulus(120, 100, 480);
    @(negedge clk);
    obstacle_xpos = 12'd120;
    player_ypos   = 12'd480;
    frame_start   = 1'b1;
    @(negedge clk);
    frame_start   = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    checkOutput("rst_game_over", 32'(game_over), 0);
    checkOutput("rst_hit_pulse", 32'(hit_pulse), 0);
    checkOutput("rst_score", 32'(score), 0);
    checkOutput("rst_score_sat", 32'(score_s), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_pending_discarded", 32'(game_over), 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
